// File: rtl/sdram_word_splitter.sv
// Splits 32-bit strobed word requests into one or two 16-bit sdram_controller
// commands. Partial halfwords use read-modify-write; reads are reassembled.
module sdram_word_splitter #(
  parameter int ADDR_WIDTH = 25,
  parameter int TIMEOUT    = 255
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-2:0] wr_addr,
  output logic [ADDR_WIDTH-2:0] rd_addr,
  output logic [15:0]           wr_data,
  output logic                  wr_enable,
  output logic                  rd_enable,
  input  logic [15:0]           rd_data,
  input  logic                  rd_ready,
  input  logic                  busy
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_SETTLE, S_WAIT_RD, S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  lane_q, lane_d;
  logic                  phase_q, phase_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-3:0] base_q, base_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [15:0]           merge_q, merge_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-2:0] addr_q, addr_d;
  logic [15:0]           wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;

  logic [1:0]  pair;
  logic [15:0] lane_wdata;
  logic [15:0] merged;
  logic        advance;

  assign pair       = lane_q ? wstrb_q[3:2] : wstrb_q[1:0];
  assign lane_wdata = lane_q ? wdata_q[31:16] : wdata_q[15:0];
  assign merged     = {pair[1] ? lane_wdata[15:8] : rd_data[15:8],
                       pair[0] ? lane_wdata[7:0]  : rd_data[7:0]};

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    phase_d     = phase_q;
    write_d     = write_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    merge_d     = merge_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    advance     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d     = req_write;
          base_d      = req_addr[ADDR_WIDTH-1:2];
          wdata_d     = req_wdata;
          wstrb_d     = req_wstrb;
          lane_d      = 1'b0;
          phase_d     = 1'b0;
          rsp_rdata_d = 32'h0;
          if (req_addr[1:0] != 2'b00) begin
            rsp_err_d = 1'b1;
            state_d   = S_RESP;
          end else begin
            rsp_err_d = 1'b0;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (write_q && !phase_q && pair == 2'b00) begin
          advance = 1'b1;
        end else if (!busy) begin
          addr_d  = {base_q, lane_q};
          state_d = S_SETTLE;
          // Write directly for full halfwords, or as the second step of RMW.
          if (write_q && (phase_q || pair == 2'b11)) begin
            wr_en_d   = 1'b1;
            wr_data_d = phase_q ? merge_q : lane_wdata;
          end else begin
            rd_en_d = 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (rd_en_q) begin
          cnt_d   = 16'h0;
          state_d = S_WAIT_RD;
        end else begin
          advance = 1'b1;
        end
      end
      S_WAIT_RD: begin
        if (rd_ready) begin
          if (write_q) begin
            merge_d = merged;
            phase_d = 1'b1;
            state_d = S_ISSUE;
          end else begin
            if (lane_q) rsp_rdata_d[31:16] = rd_data;
            else        rsp_rdata_d[15:0]  = rd_data;
            advance = 1'b1;
          end
        end else if (cnt_q == TO_LAST) begin
          rsp_err_d = 1'b1;
          advance   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'h1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'h0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      phase_d = 1'b0;
      if (lane_q) begin
        state_d = S_RESP;
      end else begin
        lane_d  = 1'b1;
        state_d = S_ISSUE;
      end
    end

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      lane_q      <= 1'b0;
      phase_q     <= 1'b0;
      write_q     <= 1'b0;
      base_q      <= '0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      merge_q     <= 16'h0;
      cnt_q       <= 16'h0;
      addr_q      <= '0;
      wr_data_q   <= 16'h0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      phase_q     <= phase_d;
      write_q     <= write_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      merge_q     <= merge_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign wr_addr   = addr_q;
  assign rd_addr   = addr_q;
  assign wr_data   = wr_data_q;
  assign wr_enable = wr_en_q;
  assign rd_enable = rd_en_q;

endmodule

// File: tb/tb_sdram_word_splitter.sv
// Directed bench for sdram_word_splitter: vector table plus hand-written
// timing, busy-stall, response-hold and reset-abort sequences.
module tb_sdram_word_splitter;

  localparam int AW = 25;

  logic          aclk = 1'b0;
  logic          resetn;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wstrb;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic [AW-2:0] wr_addr, rd_addr;
  logic [15:0]   wr_data, rd_data;
  logic          wr_enable, rd_enable, rd_ready, busy;

  sdram_word_splitter #(.ADDR_WIDTH(AW), .TIMEOUT(8)) dut (
    .aclk(aclk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .wr_data(wr_data), .wr_enable(wr_enable), .rd_enable(rd_enable),
    .rd_data(rd_data), .rd_ready(rd_ready), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        write;
    logic [24:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [15:0] rd_lo;
    logic [15:0] rd_hi;
    int          lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_nwr;
    int          exp_nrd;
    logic [15:0] exp_wlo;
    logic [15:0] exp_whi;
  } vec_t;

  vec_t vecs[11];

  // results of the most recent run_txn
  logic [31:0] o_rdata;
  logic        o_err, o_done, o_overlap, o_hold_bad;
  int          o_nwr, o_nrd, o_rsp_cyc;
  int          o_wr_cyc[2];
  int          o_rd_cyc[2];
  logic [15:0] o_wlo, o_whi;

  task automatic send_req(input logic w, input logic [24:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (!req_ready) chk("req_ready_wait", 32'(req_ready), 32'h1);
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    req_valid = 1'b1;
    @(posedge aclk);
  endtask

  task automatic run_txn(input logic w, input logic [24:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [15:0] lo, input logic [15:0] hi,
                         input int lat, input int busy_n, input int hold_n);
    int k, due, held;
    logic [15:0] pend;
    o_nwr = 0; o_nrd = 0; o_rsp_cyc = -1; o_done = 1'b0; o_overlap = 1'b0;
    o_hold_bad = 1'b0; o_wlo = 16'h0; o_whi = 16'h0; o_rdata = 32'h0; o_err = 1'b0;
    o_wr_cyc[0] = -1; o_wr_cyc[1] = -1; o_rd_cyc[0] = -1; o_rd_cyc[1] = -1;
    due = -1; held = 0; pend = 16'h0;
    busy = (busy_n > 0);
    send_req(w, a, d, s);
    k = 0;
    while (!o_done && k < 300) begin
      @(negedge aclk);
      k++;
      req_valid = 1'b0;
      busy      = (k <= busy_n);
      rd_ready  = 1'b0;
      if (wr_enable && rd_enable) o_overlap = 1'b1;
      if (wr_enable) begin
        if (o_nwr < 2) o_wr_cyc[o_nwr] = k;
        o_nwr++;
        chk("wr_addr_base", 32'(wr_addr[AW-2:1]), 32'(a[AW-1:2]));
        if (wr_addr[0]) o_whi = wr_data;
        else            o_wlo = wr_data;
      end
      if (rd_enable) begin
        if (o_nrd < 2) o_rd_cyc[o_nrd] = k;
        o_nrd++;
        chk("rd_addr_base", 32'(rd_addr[AW-2:1]), 32'(a[AW-1:2]));
        pend = rd_addr[0] ? hi : lo;
        due  = (lat > 0) ? k + lat : -1;
      end
      if (k == due) begin
        rd_ready = 1'b1;
        rd_data  = pend;
      end
      if (rsp_valid) begin
        if (o_rsp_cyc < 0) o_rsp_cyc = k;
        if (held >= hold_n) begin
          rsp_ready = 1'b1;
          o_rdata   = rsp_rdata;
          o_err     = rsp_err;
          o_done    = 1'b1;
        end else begin
          if (req_ready) o_hold_bad = 1'b1;
          held++;
        end
      end
    end
    if (!o_done) chk("rsp_timeout", 32'(o_done), 32'h1);
    @(negedge aclk);
    rsp_ready = 1'b0;
    rd_ready  = 1'b0;
    busy      = 1'b0;
    chk("rsp_dropped", 32'(rsp_valid), 32'h0);
  endtask

  logic [76:0] outs;
  assign outs = {req_ready, rsp_valid, rsp_rdata, rsp_err, wr_addr,
                 wr_data, wr_enable, rd_enable};

  initial begin
    //          wr    addr      wdata         strb   rd_lo     rd_hi    lat rdata        err  nwr nrd wlo       whi
    vecs[0]  = '{1'b1, 25'h100, 32'hDEADBEEF, 4'hF, 16'h0000, 16'h0000, 3, 32'h0,       1'b0, 2, 0, 16'hBEEF, 16'hDEAD};
    vecs[1]  = '{1'b0, 25'h200, 32'h0,        4'h0, 16'h5678, 16'h1234, 3, 32'h12345678, 1'b0, 0, 2, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b1, 25'h300, 32'h0000AB00, 4'h2, 16'h1122, 16'h0000, 3, 32'h0,       1'b0, 1, 1, 16'hAB22, 16'h0000};
    vecs[3]  = '{1'b1, 25'h400, 32'h55AA33CC, 4'h9, 16'h1122, 16'h7788, 3, 32'h0,       1'b0, 2, 2, 16'h11CC, 16'h5588};
    vecs[4]  = '{1'b1, 25'h500, 32'hFFFFFFFF, 4'h0, 16'h0000, 16'h0000, 3, 32'h0,       1'b0, 0, 0, 16'h0000, 16'h0000};
    vecs[5]  = '{1'b0, 25'h102, 32'h0,        4'h0, 16'h1111, 16'h2222, 3, 32'h0,       1'b1, 0, 0, 16'h0000, 16'h0000};
    vecs[6]  = '{1'b1, 25'h00C, 32'hCAFE0000, 4'hC, 16'h0000, 16'h0000, 3, 32'h0,       1'b0, 1, 0, 16'h0000, 16'hCAFE};
    vecs[7]  = '{1'b1, 25'h101, 32'h12345678, 4'hF, 16'h0000, 16'h0000, 3, 32'h0,       1'b1, 0, 0, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b0, 25'h600, 32'h0,        4'h0, 16'h9999, 16'h8888, 0, 32'h0,       1'b1, 0, 2, 16'h0000, 16'h0000};
    vecs[9]  = '{1'b1, 25'h700, 32'h000000EE, 4'h1, 16'h4455, 16'h0000, 0, 32'h0,       1'b1, 0, 1, 16'h0000, 16'h0000};
    vecs[10] = '{1'b0, 25'h800, 32'h0,        4'h0, 16'hBBAA, 16'hDDCC, 1, 32'hDDCCBBAA, 1'b0, 0, 2, 16'h0000, 16'h0000};

    resetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = 32'h0; req_wstrb = 4'h0; rsp_ready = 1'b0; rd_data = 16'h0;
    rd_ready = 1'b0; busy = 1'b0;
    repeat (3) @(negedge aclk);
    chk("reset_outputs", {31'h0, |outs}, 32'h0);
    resetn = 1'b1;
    repeat (2) @(negedge aclk);
    chk("reset_req_ready", 32'(req_ready), 32'h1);

    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
              vecs[i].rd_lo, vecs[i].rd_hi, vecs[i].lat, 0, 0);
      chk($sformatf("v%0d_rdata", i), o_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), 32'(o_err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_nwr", i), 32'(o_nwr), 32'(vecs[i].exp_nwr));
      chk($sformatf("v%0d_nrd", i), 32'(o_nrd), 32'(vecs[i].exp_nrd));
      chk($sformatf("v%0d_wlo", i), 32'(o_wlo), 32'(vecs[i].exp_wlo));
      chk($sformatf("v%0d_whi", i), 32'(o_whi), 32'(vecs[i].exp_whi));
      chk($sformatf("v%0d_overlap", i), 32'(o_overlap), 32'h0);
    end

    // full write cycle timing
    run_txn(1'b1, 25'h100, 32'hDEADBEEF, 4'hF, 16'h0, 16'h0, 3, 0, 0);
    chk("fw_wr0_cyc", 32'(o_wr_cyc[0]), 32'd2);
    chk("fw_wr1_cyc", 32'(o_wr_cyc[1]), 32'd4);
    chk("fw_rsp_cyc", 32'(o_rsp_cyc), 32'd5);

    // read timing with rd_ready 3 cycles after each rd_enable
    run_txn(1'b0, 25'h200, 32'h0, 4'h0, 16'h5678, 16'h1234, 3, 0, 0);
    chk("rd_rd0_cyc", 32'(o_rd_cyc[0]), 32'd2);
    chk("rd_rd1_cyc", 32'(o_rd_cyc[1]), 32'd7);
    chk("rd_rsp_cyc", 32'(o_rsp_cyc), 32'd11);

    // busy high for 10 cycles after acceptance
    run_txn(1'b1, 25'h100, 32'hDEADBEEF, 4'hF, 16'h0, 16'h0, 3, 10, 0);
    chk("busy_wr0_cyc", 32'(o_wr_cyc[0]), 32'd12);
    chk("busy_wr1_cyc", 32'(o_wr_cyc[1]), 32'd14);
    chk("busy_rsp_cyc", 32'(o_rsp_cyc), 32'd15);

    // both lanes time out, TIMEOUT = 8
    run_txn(1'b0, 25'h200, 32'h0, 4'h0, 16'h0, 16'h0, 0, 0, 0);
    chk("to_rd1_cyc", 32'(o_rd_cyc[1]), 32'd12);
    chk("to_rsp_cyc", 32'(o_rsp_cyc), 32'd21);
    chk("to_err", 32'(o_err), 32'h1);
    chk("to_rdata", o_rdata, 32'h0);

    // response held for 5 cycles blocks new requests
    run_txn(1'b0, 25'h800, 32'h0, 4'h0, 16'hBBAA, 16'hDDCC, 2, 0, 5);
    chk("hold_req_ready_low", 32'(o_hold_bad), 32'h0);
    chk("hold_rdata", o_rdata, 32'hDDCCBBAA);

    // reset while waiting for read data
    send_req(1'b0, 25'h200, 32'h0, 4'h0);
    begin
      int n;
      n = 0;
      @(negedge aclk);
      req_valid = 1'b0;
      while (!rd_enable && n < 20) begin
        @(negedge aclk);
        n++;
      end
      chk("rst_rd_seen", 32'(rd_enable), 32'h1);
      repeat (2) @(negedge aclk);
      resetn = 1'b0;
      @(negedge aclk);
      chk("rst_mid_outputs", {31'h0, |outs}, 32'h0);
      resetn   = 1'b1;
      rd_ready = 1'b1;
      rd_data  = 16'hEEEE;
      n = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge aclk);
        rd_ready = 1'b0;
        if (wr_enable || rd_enable || rsp_valid) n++;
      end
      chk("rst_no_activity", 32'(n), 32'h0);
      chk("rst_idle", 32'(req_ready), 32'h1);
    end
    run_txn(1'b0, 25'h200, 32'h0, 4'h0, 16'h5678, 16'h1234, 3, 0, 0);
    chk("post_rst_rdata", o_rdata, 32'h12345678);
    chk("post_rst_err", 32'(o_err), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
